// File: rtl/sim_run_controller.sv
// sim_run_controller: holds the core in reset, then counts cycles and retirements, and ends
// the run with a verdict from a tohost store, a timeout or a hang.
// Ports: clk, rst (sync, active-high); retire_valid, mem_we, mem_addr, mem_wdata (core taps);
//        core_rst, running, done, status, fail_code, cycle_count, retire_count (registered).
module sim_run_controller #(
    parameter int unsigned           XLEN         = 32,
    parameter int unsigned           CNT_W        = 32,
    parameter int unsigned           RESET_CYCLES = 4,
    parameter int unsigned           MAX_CYCLES   = 500,
    parameter int unsigned           HANG_LIMIT   = 64,
    parameter logic [XLEN-1:0]       TOHOST_ADDR  = 32'h0000_0FFC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid,
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic [2:0]       status,
    output logic [XLEN-1:0]  fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    localparam int unsigned RC_W = $clog2(RESET_CYCLES) + 1;

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_PASS    = 3'd1;
    localparam logic [2:0] ST_FAIL    = 3'd2;
    localparam logic [2:0] ST_TIMEOUT = 3'd3;
    localparam logic [2:0] ST_HANG    = 3'd4;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [RC_W-1:0]   rst_cnt, rst_cnt_n;
    logic [CNT_W-1:0]  idle_cnt, idle_n;
    logic [CNT_W-1:0]  cyc_n, ret_n;
    logic [2:0]        status_n;
    logic [XLEN-1:0]   fail_n;
    logic              tohost;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign tohost = mem_we && (mem_addr == TOHOST_ADDR);

    always_comb begin
        state_n   = state;
        rst_cnt_n = rst_cnt;
        idle_n    = idle_cnt;
        cyc_n     = cycle_count;
        ret_n     = retire_count;
        status_n  = status;
        fail_n    = fail_code;
        unique case (state)
            S_RESET: begin
                rst_cnt_n = rst_cnt + RC_W'(1);
                if (rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                cyc_n  = sat_inc(cycle_count);
                ret_n  = retire_valid ? sat_inc(retire_count) : retire_count;
                idle_n = retire_valid ? '0 : sat_inc(idle_cnt);
                // The terminating cycle is still counted above.
                if (tohost) begin
                    state_n = S_DONE;
                    if (mem_wdata == XLEN'(1)) begin
                        status_n = ST_PASS;
                    end else begin
                        status_n = ST_FAIL;
                        fail_n   = mem_wdata >> 1;
                    end
                end else if (idle_cnt == CNT_W'(HANG_LIMIT - 1) && !retire_valid) begin
                    state_n  = S_DONE;
                    status_n = ST_HANG;
                end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
                    state_n  = S_DONE;
                    status_n = ST_TIMEOUT;
                end
            end
            S_DONE: begin
                state_n = S_DONE;
            end
            default: begin
                state_n = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_RESET;
            rst_cnt      <= '0;
            idle_cnt     <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
            status       <= ST_NONE;
            fail_code    <= '0;
            core_rst     <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            rst_cnt      <= rst_cnt_n;
            idle_cnt     <= idle_n;
            cycle_count  <= cyc_n;
            retire_count <= ret_n;
            status       <= status_n;
            fail_code    <= fail_n;
            // Flag outputs follow the next state so they line up with it.
            core_rst     <= (state_n != S_RUN);
            running      <= (state_n == S_RUN);
            done         <= (state_n == S_DONE);
        end
    end

endmodule
